pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//   Parametrised, pipelined multi-mode barrel shifter for the RISC execute stage; next generation of
//   the 5-level 32-bit combinational left shifter. Supports SLL/SRL/SRA/ROL/ROR at any power-of-2 width.
//   Log2 mux levels, grouped into registered pipeline stages, with valid/ready handshake at both ends.
//   Full throughput of 1 op/cycle when downstream is ready.
// PARAMETERS
//   WIDTH      32  data width; must be a power of 2, >= 2
//   SHW        $clog2(WIDTH)  shift-amount width (derived; do not override)
//   REG_EVERY  2   mux levels per pipeline stage; latency L = ceil(SHW/REG_EVERY) cycles (default L=3)
// PORTS
//   clk         in   1      clock, rising edge
//   reset       in   1      synchronous, active-high reset
//   in_valid    in   1      input op valid
//   in_ready    out  1      shifter can accept input this cycle
//   in_data     in   WIDTH  operand
//   in_shamt    in   SHW    shift amount, unsigned 0..WIDTH-1
//   in_op       in   3      op code (see package)
//   out_valid   out  1      result valid
//   out_ready   in   1      downstream accepts result
//   out_data    out  WIDTH  shifted result
//   out_illegal out  1      result came from a reserved op code
// BEHAVIOUR
//   - Op codes: SLL=0, SRL=1, SRA=2, ROL=3, ROR=4; 5..7 reserved -> data passed through unshifted,
//     out_illegal=1. Legal ops -> out_illegal=0.
//   - Mux level k (k=0..SHW-1) shifts by 2^k when shamt[k]=1, else passes. Fill: SLL/SRL zeros;
//     SRA replicates in_data[WIDTH-1] (sign captured at accept, carried down the pipe); ROL/ROR wrap bits.
//   - Levels applied in ascending k; register after every REG_EVERY levels and after the last level.
//     Each stage register holds {valid, data, remaining shamt bits, op, sign, illegal}.
//   - Transfer on in_valid&&in_ready (accept) and out_valid&&out_ready (retire).
//   - Stage i advances when !v[i] || advance[i+1]; last stage advance = !v[L-1] || out_ready.
//     in_ready = advance[0] (combinational from out_ready through valids; no registered skid).
//   - Latency: op accepted in cycle t appears with out_valid=1 in cycle t+L when no stall.
//   - Backpressure: out_ready=0 holds out_data/out_valid/out_illegal stable; pipe compresses bubbles;
//     once all L stages full, in_ready=0. No op lost, duplicated, or reordered.
//   - Bubbles: in_valid=0 while advancing inserts v=0; out_valid drops for that slot only.
//   - shamt=0 -> out_data = in_data for every legal op.
//   - Reset: every stage valid cleared on the clock edge reset is high; out_valid=0, out_data=0,
//     out_illegal=0; in_ready=1 from first cycle after reset deasserts. Ops in flight at reset are
//     discarded; input presented during reset is not accepted.
//   - Data regs of invalid stages are don't-care internally but out_data reads 0 while out_valid=0
//     after reset until first retire.
// STRUCTURE
//   - Package shifter_pkg: op localparams (OP_SLL..OP_ROR), op width 3, is_legal_op function.
//   - Sub-module shift_level: one combinational mux level, params WIDTH, DIST; ports data, en, op,
//     sign -> data_out. Top generates SHW instances, inserts stage registers + valid/ready control.
// TESTING
//   1 SLL 0x00000001 shamt 31 -> 0x80000000 at cycle t+3, out_illegal=0.
//   2 SRL/SRA/ROR on 0x80000000 shamt 4 -> 0x08000000 / 0xF8000000 / 0x08000000;
//     ROR 0x12345678 shamt 8 -> 0x78123456; ROL same -> 0x34567812.
//   3 Back-to-back 8 ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order.
//   4 out_ready=0 for 6 cycles while streaming -> in_ready falls after 3 accepts; out_data stable;
//     on release all results emerge in order, none lost.
//   5 Reset asserted with 3 ops in flight -> out_valid=0 next cycle, none of those ops ever retires.
//   6 op=7, data 0xDEADBEEF, shamt 5 -> out_data=0xDEADBEEF, out_illegal=1; shamt 0 all legal ops -> unchanged;
//     rerun 1-4 with WIDTH=16, REG_EVERY=1 (L=4) and WIDTH=64, REG_EVERY=3 (L=2).

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared op encodings and helpers for the pipelined barrel shifter.
package shifter_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'd0;
    localparam logic [OP_W-1:0] OP_SRL = 3'd1;
    localparam logic [OP_W-1:0] OP_SRA = 3'd2;
    localparam logic [OP_W-1:0] OP_ROL = 3'd3;
    localparam logic [OP_W-1:0] OP_ROR = 3'd4;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational mux level: shifts/rotates by DIST when en is set, else passes data through.
module shift_level
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [OP_W-1:0]  op,
    input  logic             sign,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [WIDTH-1:0] ONES      = '1;
    localparam logic [WIDTH-1:0] SIGN_FILL = ~(ONES >> DIST);

    always_comb begin
        data_out = data;
        if (en) begin
            case (op)
                OP_SLL:  data_out = data << DIST;
                OP_SRL:  data_out = data >> DIST;
                OP_SRA:  data_out = (data >> DIST) | (sign ? SIGN_FILL : '0);
                OP_ROL:  data_out = (data << DIST) | (data >> (WIDTH - DIST));
                OP_ROR:  data_out = (data >> DIST) | (data << (WIDTH - DIST));
                default: data_out = data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter: SHW mux levels, a register after every REG_EVERY levels,
// valid/ready handshake on both ends with a combinational ready chain.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SHW       = $clog2(WIDTH),
    parameter int unsigned REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_illegal
);

    localparam int unsigned L = (SHW + REG_EVERY - 1) / REG_EVERY;

    // Stage registers
    logic             v_q    [L];
    logic [WIDTH-1:0] d_q    [L];
    logic [SHW-1:0]   sh_q   [L];
    logic [OP_W-1:0]  op_q   [L];
    logic             sign_q [L];
    logic             ill_q  [L];

    // Per-stage inputs (previous register or the input port) and mux-chain result
    logic             sin_v    [L];
    logic [WIDTH-1:0] sin_data [L];
    logic [SHW-1:0]   sin_sh   [L];
    logic [OP_W-1:0]  sin_op   [L];
    logic             sin_sign [L];
    logic             sin_ill  [L];
    logic [WIDTH-1:0] sout_data[L];

    logic             adv [L];

    for (genvar k = 0; k < SHW; k++) begin : lv
        localparam int unsigned S = k / REG_EVERY;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] dout;

        if (k % REG_EVERY == 0) begin : g_head
            assign din = sin_data[S];
        end else begin : g_chain
            assign din = lv[k-1].dout;
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (2 ** k)
        ) u_level (
            .data     (din),
            .en       (sin_sh[S][k]),
            .op       (sin_op[S]),
            .sign     (sin_sign[S]),
            .data_out (dout)
        );
    end

    for (genvar s = 0; s < L; s++) begin : stg
        localparam int unsigned LAST =
            (((s + 1) * REG_EVERY < SHW) ? (s + 1) * REG_EVERY : SHW) - 1;

        if (s == 0) begin : g_first
            assign sin_v[s]    = in_valid;
            assign sin_data[s] = in_data;
            assign sin_sh[s]   = in_shamt;
            assign sin_op[s]   = in_op;
            assign sin_sign[s] = in_data[WIDTH-1];
            assign sin_ill[s]  = !is_legal_op(in_op);
        end else begin : g_rest
            assign sin_v[s]    = v_q[s-1];
            assign sin_data[s] = d_q[s-1];
            assign sin_sh[s]   = sh_q[s-1];
            assign sin_op[s]   = op_q[s-1];
            assign sin_sign[s] = sign_q[s-1];
            assign sin_ill[s]  = ill_q[s-1];
        end

        assign sout_data[s] = lv[LAST].dout;
    end

    // Ready ripples back from out_ready; an empty stage can always take a new entry.
    always_comb begin
        logic nxt;
        adv = '{default: 1'b0};
        nxt = out_ready;
        for (int unsigned j = 0; j < L; j++) begin
            nxt          = !v_q[L-1-j] || nxt;
            adv[L-1-j]   = nxt;
        end
    end

    assign in_ready = adv[0];

    // Payload loads only with a valid entry so out_data stays 0 until the first real result.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < L; i++) begin
                v_q[i]    <= 1'b0;
                d_q[i]    <= '0;
                sh_q[i]   <= '0;
                op_q[i]   <= '0;
                sign_q[i] <= 1'b0;
                ill_q[i]  <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < L; i++) begin
                if (adv[i]) begin
                    v_q[i] <= sin_v[i];
                    if (sin_v[i]) begin
                        d_q[i]    <= sout_data[i];
                        sh_q[i]   <= sin_sh[i];
                        op_q[i]   <= sin_op[i];
                        sign_q[i] <= sin_sign[i];
                        ill_q[i]  <= sin_ill[i];
                    end
                end
            end
        end
    end

    assign out_valid   = v_q[L-1];
    assign out_data    = d_q[L-1];
    assign out_illegal = ill_q[L-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: three shifter configurations (16/L4, 32/L3, 64/L2) against a bit-level reference model.
module tb_pipelined_barrel_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [63:0] in_data   [3];
    logic [5:0]  in_shamt  [3];
    logic [2:0]  in_op     [3];
    logic        ov        [3];
    logic        out_ready [3];
    logic        oill      [3];
    logic [15:0] od16;
    logic [31:0] od32;
    logic [63:0] od64;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        last_acc;
    logic        last_ret;
    logic [63:0] nxt_exp;
    logic        nxt_ill;
    logic [64:0] expq[$];
    int          rq[$];

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(16), .REG_EVERY(1)) u16 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0][15:0]), .in_shamt(in_shamt[0][3:0]), .in_op(in_op[0]),
        .out_valid(ov[0]), .out_ready(out_ready[0]), .out_data(od16), .out_illegal(oill[0]));

    pipelined_barrel_shifter #(.WIDTH(32), .REG_EVERY(2)) u32 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1][31:0]), .in_shamt(in_shamt[1][4:0]), .in_op(in_op[1]),
        .out_valid(ov[1]), .out_ready(out_ready[1]), .out_data(od32), .out_illegal(oill[1]));

    pipelined_barrel_shifter #(.WIDTH(64), .REG_EVERY(3)) u64 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_shamt(in_shamt[2]), .in_op(in_op[2]),
        .out_valid(ov[2]), .out_ready(out_ready[2]), .out_data(od64), .out_illegal(oill[2]));

    function automatic int wid(input int d);
        return (d == 0) ? 16 : (d == 1) ? 32 : 64;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 4 : (d == 1) ? 3 : 2;
    endfunction

    function automatic logic [63:0] odata(input int d);
        return (d == 0) ? {48'b0, od16} : (d == 1) ? {32'b0, od32} : od64;
    endfunction

    function automatic logic [63:0] wmask(input int w);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < w; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Reference: result bit i taken straight from the operation's definition.
    function automatic logic [63:0] model(input int w, input logic [63:0] dd, input int sh,
                                          input logic [2:0] op);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                3'd0:    r[i] = (i >= sh) ? dd[i-sh] : 1'b0;
                3'd1:    r[i] = (i + sh < w) ? dd[i+sh] : 1'b0;
                3'd2:    r[i] = (i + sh < w) ? dd[i+sh] : dd[w-1];
                3'd3:    r[i] = dd[(i - sh + w) % w];
                3'd4:    r[i] = dd[(i + sh) % w];
                default: r[i] = dd[i];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called at negedge with inputs driven; scores handshakes then moves to the next negedge.
    task automatic cycle(input int d);
        logic [64:0] e;
        #1;
        last_acc = in_valid[d] && in_ready[d] && !reset;
        last_ret = ov[d] && out_ready[d] && !reset;
        if (last_ret) begin
            chk("retire_expected", 65'(expq.size() > 0), 65'(1));
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("result", {oill[d], odata(d)}, e);
            end
            rq.push_back(cyc);
        end
        if (last_acc) expq.push_back({nxt_ill, nxt_exp});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic load(input int d, input logic [2:0] op, input logic [63:0] dd, input int sh,
                        input logic [63:0] ex, input logic ill);
        in_valid[d] = 1'b1;
        in_op[d]    = op;
        in_data[d]  = dd;
        in_shamt[d] = 6'(sh);
        nxt_exp     = ex;
        nxt_ill     = ill;
    endtask

    task automatic send_lit(input int d, input logic [2:0] op, input logic [63:0] dd,
                            input int sh, input logic [63:0] ex, input logic ill);
        load(d, op, dd, sh, ex, ill);
        cycle(d);
        chk("accept", 65'(last_acc), 65'(1));
    endtask

    task automatic drain(input int d);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        for (int i = 0; i < 60 && expq.size() > 0; i++) cycle(d);
        chk("drain_empty", 65'(expq.size()), 65'(0));
    endtask

    // mode 0: always ready; mode 1: out_ready low for the first 6 cycles; mode 2: random both ends
    task automatic run_stream(input int d, input int n, input int mode);
        int          sent = 0;
        int          acc_cnt = 0;
        int          c = 0;
        logic        pend = 1'b0;
        logic        held_v = 1'b0;
        logic [64:0] held = '0;
        logic [63:0] dd;
        logic [2:0]  op;
        int          sh;
        int          w;
        w = wid(d);
        rq.delete();
        while ((sent < n || pend) && c < 2000) begin
            if (!pend && sent < n && (mode != 2 || $urandom_range(0, 3) != 0)) begin
                dd   = {$urandom, $urandom} & wmask(w);
                op   = 3'($urandom_range(0, 7));
                sh   = $urandom_range(0, w - 1);
                pend = 1'b1;
                sent++;
                load(d, op, dd, sh, model(w, dd, sh, op), op > 3'd4);
            end
            in_valid[d]  = pend;
            out_ready[d] = (mode == 1) ? (c >= 6) :
                           (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
            cycle(d);
            if (mode == 0) chk("b2b_accept", 65'(last_acc), 65'(1));
            if (mode == 1 && c < 6) chk("bp_in_ready", 65'(last_acc), 65'(acc_cnt < lat(d)));
            if (last_acc) begin
                pend = 1'b0;
                acc_cnt++;
            end
            if (mode == 1 && c < 6 && ov[d]) begin
                if (held_v) chk("bp_stable", {oill[d], odata(d)}, held);
                held   = {oill[d], odata(d)};
                held_v = 1'b1;
            end
            c++;
        end
        drain(d);
        chk("retire_count", 65'(rq.size()), 65'(n));
        if (mode == 0 && rq.size() == n) chk("b2b_consecutive", 65'(rq[n-1] - rq[0]), 65'(n - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_shamt[d]  = '0;
            in_op[d]     = '0;
            out_ready[d] = 1'b1;
        end
        nxt_exp = '0;
        nxt_ill = 1'b0;
        // Offer an op during reset: it must never come out.
        load(1, 3'd0, 64'h1234_5678, 4, 64'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_valid", 65'(ov[d]), 65'(0));
            chk("reset_data", 65'(odata(d)), 65'(0));
            chk("reset_illegal", 65'(oill[d]), 65'(0));
        end
        reset = 1'b0;
        in_valid[1] = 1'b0;
        for (int d = 0; d < 3; d++) chk("ready_after_reset", 65'(in_ready[d]), 65'(1));
        for (int i = 0; i < 5; i++) begin
            cycle(1);
            chk("no_accept_in_reset", 65'(ov[1]), 65'(0));
            chk("data_zero_idle", 65'(odata(1)), 65'(0));
        end

        // SLL of 1 by W-1 with exact latency check, on every configuration
        for (int d = 0; d < 3; d++) begin
            send_lit(d, 3'd0, 64'd1, wid(d) - 1, 64'd1 << (wid(d) - 1), 1'b0);
            in_valid[d] = 1'b0;
            for (int c = 1; c <= lat(d); c++) begin
                chk("latency_valid", 65'(ov[d]), 65'(c == lat(d)));
                if (c < lat(d)) cycle(d);
            end
            chk("sll_msb", 65'(odata(d)), 65'(64'd1 << (wid(d) - 1)));
            chk("sll_legal", 65'(oill[d]), 65'(0));
            drain(d);
        end

        // Directed 32-bit vectors, streamed back-to-back
        send_lit(1, 3'd1, 64'h8000_0000, 4, 64'h0800_0000, 1'b0);
        send_lit(1, 3'd2, 64'h8000_0000, 4, 64'hF800_0000, 1'b0);
        send_lit(1, 3'd4, 64'h8000_0000, 4, 64'h0800_0000, 1'b0);
        send_lit(1, 3'd4, 64'h1234_5678, 8, 64'h7812_3456, 1'b0);
        send_lit(1, 3'd3, 64'h1234_5678, 8, 64'h3456_7812, 1'b0);
        send_lit(1, 3'd7, 64'hDEAD_BEEF, 5, 64'hDEAD_BEEF, 1'b1);
        send_lit(1, 3'd5, 64'h0000_0001, 1, 64'h0000_0001, 1'b1);
        send_lit(1, 3'd2, 64'h4000_0000, 31, 64'h0000_0000, 1'b0);
        send_lit(1, 3'd2, 64'hC000_0000, 31, 64'hFFFF_FFFF, 1'b0);
        drain(1);

        // shamt = 0 leaves data unchanged for every legal op, every width
        for (int d = 0; d < 3; d++) begin
            logic [63:0] dd;
            for (int op = 0; op < 5; op++) begin
                dd = {$urandom, $urandom} & wmask(wid(d));
                send_lit(d, 3'(op), dd, 0, dd, 1'b0);
            end
            drain(d);
        end

        // Throughput, backpressure and random traffic on every configuration
        for (int d = 0; d < 3; d++) begin
            run_stream(d, 8, 0);
            run_stream(d, 10, 1);
            run_stream(d, 40, 2);
        end

        // Reset with three ops in flight: none of them may ever retire
        for (int i = 0; i < 3; i++) send_lit(1, 3'd0, 64'h0000_00FF, i, 64'h0, 1'b0);
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        reset        = 1'b1;
        cycle(1);
        chk("flush_valid", 65'(ov[1]), 65'(0));
        chk("flush_data", 65'(odata(1)), 65'(0));
        chk("flush_illegal", 65'(oill[1]), 65'(0));
        expq.delete();
        reset        = 1'b0;
        out_ready[1] = 1'b1;
        chk("flush_ready", 65'(in_ready[1]), 65'(1));
        for (int i = 0; i < 6; i++) begin
            cycle(1);
            chk("flush_no_retire", 65'(ov[1]), 65'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
